// File: rtl/tpg_pkg.sv
// Shared definitions for the test-pattern generator.
//   PAT_*    : pattern_sel encodings
//   BAR_LUT  : {R,G,B} on/off bits for each of the eight colour bars
//   clog2    : counter-width helper (never returns less than 1)
package tpg_pkg;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    // Index 0..7: white, yellow, cyan, green, magenta, red, blue, black.
    // Entry i is {~i[1], ~i[2], ~i[0]}.
    localparam logic [7:0][2:0] BAR_LUT = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tpg_timing.sv
// Raster timing core: horizontal/vertical counters, sync and data-enable
// generation, and the frame-start pulse.
//   clk, reset    : pixel clock, synchronous active-high reset
//   enable        : low forces counters to (0,0) and outputs to idle levels
//   h_cnt, v_cnt  : current raster position (combinational view of counters)
//   active        : current position lies in the active area
//   first         : current position is (0,0)
//   hsync, vsync, de, frame_start : registered, one cycle after the position
module tpg_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int H_W      = 10,
    parameter int V_W      = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           active,
    output logic           first,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           frame_start
);

    localparam logic [H_W-1:0] H_ACT   = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [V_W-1:0] V_ACT   = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic           HS_ON   = 1'(HS_POL);
    localparam logic           VS_ON   = 1'(VS_POL);

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign first  = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            // Disabling aborts the frame outright; the next enabled cycle is (0,0).
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_ON : ~HS_ON;
            // v_cnt only moves on the h wrap, so vsync edges land on h_cnt = 0.
            vsync       <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_ON : ~VS_ON;
            de          <= active;
            frame_start <= first;
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tpg_video_gen.sv
// Video timing and test-pattern generator feeding TMDS encoders
// (VDE = de, CD = {vsync, hsync}).
//   clk, reset   : pixel clock, synchronous active-high reset
//   enable       : run the raster; low holds the generator idle
//   pattern_sel  : 0 colour bars, 1 ramp, 2 checkerboard, 3 solid
//   solid_rgb    : {R,G,B} for the solid pattern
//   hsync, vsync, de, red, green, blue, frame_start : registered, mutually aligned
// Optional build macro TPG_MOVING_BOX_EN adds a bouncing inverted box
// (BOX_SIZE parameter exists only in that build).
module tpg_video_gen
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int COLOR_W    = 8,
    parameter int CHECK_LOG2 = 5
`ifdef TPG_MOVING_BOX_EN
    ,
    parameter int BOX_SIZE   = 64
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = clog2(H_TOTAL);
    localparam int V_W     = clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           active;
    logic           first;

    tpg_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .first       (first),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start)
    );

    // Pattern controls are captured at (0,0). Pixel (0,0) itself uses the
    // live inputs so the whole new frame sees the new selection.
    logic [1:0]           pat_q;
    logic [1:0]           pat_eff;
    logic [3*COLOR_W-1:0] solid_q;
    logic [3*COLOR_W-1:0] solid_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else if (enable && first) begin
            pat_q   <= pattern_sel;
            solid_q <= solid_rgb;
        end
    end

    assign pat_eff   = first ? pattern_sel : pat_q;
    assign solid_eff = first ? solid_rgb   : solid_q;

    // Bar index by comparator chain against constant thresholds.
    logic [2:0] bar_idx;
    logic [2:0] bar_bits;

    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= H_W'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    assign bar_bits = BAR_LUT[bar_idx];

    // Checker bit selects; a bit beyond the counter width is always 0.
    logic chk_h;
    logic chk_v;

    if (CHECK_LOG2 < H_W) begin : g_chk_h
        assign chk_h = h_cnt[CHECK_LOG2];
    end else begin : g_chk_h0
        assign chk_h = 1'b0;
    end

    if (CHECK_LOG2 < V_W) begin : g_chk_v
        assign chk_v = v_cnt[CHECK_LOG2];
    end else begin : g_chk_v0
        assign chk_v = 1'b0;
    end

    logic [COLOR_W-1:0]   ramp_val;
    logic [3*COLOR_W-1:0] base_rgb;
    logic [3*COLOR_W-1:0] pix_rgb;
    logic [3*COLOR_W-1:0] rgb_q;

    assign ramp_val = COLOR_W'(h_cnt);

    always_comb begin
        base_rgb = '0;
        case (pat_eff)
            PAT_BARS:  base_rgb = {{COLOR_W{bar_bits[2]}},
                                   {COLOR_W{bar_bits[1]}},
                                   {COLOR_W{bar_bits[0]}}};
            PAT_RAMP:  base_rgb = {ramp_val, ramp_val, ramp_val};
            PAT_CHECK: base_rgb = {3*COLOR_W{chk_h ^ chk_v}};
            default:   base_rgb = solid_eff;
        endcase
    end

`ifdef TPG_MOVING_BOX_EN
    localparam int             X_MAX     = H_ACTIVE - BOX_SIZE;
    localparam int             Y_MAX     = V_ACTIVE - BOX_SIZE;
    localparam logic [H_W-1:0] BOX_X_MAX = H_W'(X_MAX);
    localparam logic [V_W-1:0] BOX_Y_MAX = V_W'(Y_MAX);
    localparam logic [H_W-1:0] BOX_H     = H_W'(BOX_SIZE);
    localparam logic [V_W-1:0] BOX_V     = V_W'(BOX_SIZE);

    logic [H_W-1:0] box_x;
    logic [V_W-1:0] box_y;
    logic           dir_x;
    logic           dir_y;
    logic           frame_end;
    logic           in_box;

    // Stepping on the last raster cycle makes the new position valid from
    // the next frame's pixel (0,0); aborted frames do not move the box.
    assign frame_end = (h_cnt == H_W'(H_TOTAL - 1)) && (v_cnt == V_W'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (enable && frame_end) begin
            if (X_MAX > 0) begin
                if (dir_x) begin
                    box_x <= box_x + 1'b1;
                    if (box_x + 1'b1 == BOX_X_MAX) dir_x <= 1'b0;
                end else begin
                    box_x <= box_x - 1'b1;
                    if (box_x == H_W'(1)) dir_x <= 1'b1;
                end
            end
            if (Y_MAX > 0) begin
                if (dir_y) begin
                    box_y <= box_y + 1'b1;
                    if (box_y + 1'b1 == BOX_Y_MAX) dir_y <= 1'b0;
                end else begin
                    box_y <= box_y - 1'b1;
                    if (box_y == V_W'(1)) dir_y <= 1'b1;
                end
            end
        end
    end

    assign in_box  = (h_cnt >= box_x) && (h_cnt < box_x + BOX_H) &&
                     (v_cnt >= box_y) && (v_cnt < box_y + BOX_V);
    assign pix_rgb = in_box ? ~base_rgb : base_rgb;
`else
    assign pix_rgb = base_rgb;
`endif

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= active ? pix_rgb : '0;
        end
    end

    assign red   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_tpg_video_gen.sv
module tb_tpg_video_gen;

    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 3;
    localparam int VA  = 8;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int CL  = 2;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FR  = HT * VT;
`ifdef TPG_MOVING_BOX_EN
    localparam int BOX = 4;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    tpg_video_gen #(
        .H_ACTIVE   (HA),
        .H_FP       (HF),
        .H_SYNC     (HSW),
        .H_BP       (HB),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VSW),
        .V_BP       (VB),
        .HS_POL     (0),
        .VS_POL     (0),
        .COLOR_W    (8),
        .CHECK_LOG2 (CL)
`ifdef TPG_MOVING_BOX_EN
        ,
        .BOX_SIZE   (BOX)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    // Raster position is a single frame offset; x/y come from div/mod.
    localparam logic [27:0] IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
    logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          pos;
    int          nfr;
    int          mx, my, idx;
    int          lat_pat;
    logic [23:0] lat_solid;
    logic [23:0] col;
    logic        mact, mhs, mvs;
    logic [27:0] exp_vec;
    logic        mdl_ok = 1'b0;

`ifdef TPG_MOVING_BOX_EN
    function automatic int bounce(input int n, input int m);
        int p;
        if (m <= 0) return 0;
        p = n % (2 * m);
        return (p <= m) ? p : 2 * m - p;
    endfunction
`endif

    always @(posedge clk) begin
        if (reset) begin
            pos = 0; nfr = 0; lat_pat = 0; lat_solid = 24'h0;
            exp_vec = IDLE;
        end else if (!enable) begin
            pos = 0;
            exp_vec = IDLE;
        end else begin
            mx = pos % HT;
            my = pos / HT;
            if (pos == 0) begin
                lat_pat   = int'(pattern_sel);
                lat_solid = solid_rgb;
            end
            mact = (mx < HA) && (my < VA);
            mhs  = !(mx >= HA + HF && mx < HA + HF + HSW);
            mvs  = !(my >= VA + VF && my < VA + VF + VSW);
            case (lat_pat)
                0: begin
                    idx = mx / (HA / 8);
                    if (idx > 7) idx = 7;
                    col = bar_col[idx];
                end
                1: col = 24'((mx % 256) * 24'h010101);
                2: col = (((mx >> CL) ^ (my >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
                default: col = lat_solid;
            endcase
`ifdef TPG_MOVING_BOX_EN
            if (mx >= bounce(nfr, HA - BOX) && mx < bounce(nfr, HA - BOX) + BOX &&
                my >= bounce(nfr, VA - BOX) && my < bounce(nfr, VA - BOX) + BOX)
                col = ~col;
`endif
            if (!mact) col = 24'h0;
            exp_vec = {mhs, mvs, mact, (pos == 0), col};
            if (pos == FR - 1) nfr++;
            pos = (pos + 1) % FR;
        end
        mdl_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            total++;
            if ({hsync, vsync, de, frame_start, red, green, blue} !== exp_vec) begin
                bad++;
                $display("FAIL model_cmp t=%0t got hs/vs/de/fs/rgb=%h want=%h", $time,
                         {hsync, vsync, de, frame_start, red, green, blue}, exp_vec);
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    int n;
    task automatic adv(input int k);
        repeat (k) @(negedge clk);
        n += k;
    endtask

    int off_cnt;

    initial begin
        reset = 1'b1; enable = 1'b1; pattern_sel = 2'd0; solid_rgb = 24'h0;
        repeat (3) @(negedge clk);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'h0);
        reset = 1'b0;
        n = 0;
        adv(1);   chk("fs_first", 32'(frame_start), 32'd1);
        adv(287); chk("fs_before_2nd", 32'(frame_start), 32'd0);
        adv(1);   chk("fs_second", 32'(frame_start), 32'd1);
        adv(4);   chk("bar_x4_cyan", 32'({red, green, blue}), 32'h00FFFF);
        adv(10);  chk("bar_x14_black", 32'({red, green, blue}), 32'h000000);
                  chk("de_x14", 32'(de), 32'd1);
        adv(2);   chk("de_x16", 32'(de), 32'd0);
                  chk("rgb_blank_x16", 32'({red, green, blue}), 32'h0);
        adv(1);   chk("hs_x17", 32'(hsync), 32'd1);
        adv(1);   chk("hs_x18", 32'(hsync), 32'd0);
        adv(2);   chk("hs_x20", 32'(hsync), 32'd0);
        adv(1);   chk("hs_x21", 32'(hsync), 32'd1);
        adv(194); chk("vs_line8_end", 32'(vsync), 32'd1);
        adv(1);   chk("vs_line9", 32'(vsync), 32'd0);
        adv(71);  pattern_sel = 2'd3; solid_rgb = 24'h123456;
        adv(100); pattern_sel = 2'd1;
        adv(24);  chk("solid_midframe", 32'({red, green, blue}), 32'h123456);
        adv(170); chk("ramp_next_frame_x5", 32'({red, green, blue}), 32'h050505);
        adv(73);  chk("pre_drop_de", 32'(de), 32'd1);
                  enable = 1'b0;
        adv(1);   chk("drop_idle", 32'({hsync, vsync, de, frame_start, red, green, blue}),
                      32'(IDLE));
        adv(9);   enable = 1'b1;
        adv(1);   chk("fs_reenable", 32'(frame_start), 32'd1);

        off_cnt = 0;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 1999) == 0);
            if (off_cnt > 0) begin
                off_cnt--;
                enable = (off_cnt == 0);
            end else if ($urandom_range(0, 999) == 0) begin
                enable  = 1'b0;
                off_cnt = $urandom_range(1, 30);
            end
            if ($urandom_range(0, 99) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) solid_rgb = 24'($urandom);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpg_video_gen.md
Name: tpg_video_gen

Overview:
- Parametrised video timing and test-pattern generator. It is the next generation of the fixed-mode VGA controller path that feeds the TMDS encoders.
- Produces hsync, vsync, data-enable and RGB in the pixel clock domain. Its outputs connect directly to TMDS encoder inputs (VDE = de, CD = {vsync, hsync}).
- Raster geometry, sync polarity, colour depth and pattern are all selectable, so one instance covers any CEA/VESA mode that fits the serializer clock.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- COLOR_W, 8, bits per colour channel
- CHECK_LOG2, 5, checkerboard cell size is 2^CHECK_LOG2 pixels
- BOX_SIZE, 64, moving-box edge length (used only with the optional feature)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run raster; low holds generator idle
- pattern_sel  in  2  0 colour bars, 1 ramp, 2 checkerboard, 3 solid
- solid_rgb  in  3*COLOR_W  {R,G,B} used for pattern 3
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  active video (high in active area)
- red, green, blue  out  COLOR_W each  pixel colour, 0 when de low
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counter widths are clog2 of the totals.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments on h wrap and counts 0..V_TOTAL-1. Active region comes first: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for whole lines with V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, changing at h_cnt = 0.
- Latency: every output is registered one cycle after the counter state it reflects. All outputs are mutually aligned.
- Reset: counters = 0, hsync = !HS_POL, vsync = !VS_POL, de = 0, RGB = 0, frame_start = 0. Counting starts at (0,0) in the first cycle after reset deasserts, if enable is high.
- enable low: counters are forced to (0,0) and outputs are driven to the reset values. When enable rises, the frame starts at (0,0) that cycle. Deasserting enable mid-frame aborts the frame immediately, with no partial-line completion.
- pattern_sel and solid_rgb are latched only when h_cnt = 0 and v_cnt = 0. Changes mid-frame take effect next frame; no tearing.
- Colour bars:
  - bar index = h_cnt / (H_ACTIVE/8), clamped to 7. The divide is done by comparator chain or precomputed constant, with no runtime divider.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - R = ~idx[1], G = ~idx[2], B = ~idx[0]. Each bit expands to all-ones/all-zeros COLOR_W.
- Ramp: R = G = B = h_cnt[COLOR_W-1:0], wrapping for widths above 2^COLOR_W.
- Checkerboard: white when h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2] is 1, else black.
- Solid: latched solid_rgb.
- Blanking: RGB = 0 whenever de is low, regardless of pattern.

Optional Feature:
- Macro TPG_MOVING_BOX_EN.
- When defined: a BOX_SIZE x BOX_SIZE box overlays the pattern, drawn as the bitwise inverse of the underlying RGB.
  - Position registers box_x and box_y, plus direction bits, reset to 0 / +1.
  - Position updates by one pixel per axis at each frame start.
  - Direction reverses when box_x reaches H_ACTIVE-BOX_SIZE (or 0); the same applies to box_y with V_ACTIVE-BOX_SIZE. The box never leaves the active area.
- When undefined: no box logic is synthesised and output equals the base pattern.

Decomposition:
- Shared package tpg_pkg holds:
  - the pattern_sel encoding constants (PAT_BARS = 0, PAT_RAMP = 1, PAT_CHECK = 2, PAT_SOLID = 3);
  - the colour-bar RGB lookup constant;
  - a clog2 helper function.
- One sub-module, tpg_timing: counters, sync/de generation and frame-start detect. The top level adds pattern and box logic.

Test Plan:
Small mode used throughout: H 16/2/3/3, V 8/1/2/1, COLOR_W = 8. This gives H_TOTAL = 24, V_TOTAL = 12, frame = 288 cycles.
- reset high 3 cycles, then release with enable = 1 -> frame_start = 1 at cycle 1 after release, again at cycle 289; hsync = 1 and de = 0 during reset.
- Steady run -> hsync low for exactly 3 cycles starting 19 cycles after each line start; vsync low for lines 9-10 (48 cycles); de high 16 cycles per line on lines 0-7 only.
- pattern_sel = 0 -> output pixel x = 4 shows R = 00, G = FF, B = FF (cyan); x = 14 shows 00/00/00; all channels 0 when de = 0.
- pattern_sel changed from 3 to 1 at mid-frame (solid_rgb = 0x123456) -> remainder of frame stays 12/34/56; next frame, pixel x = 5 shows 05/05/05.
- enable dropped at line 3, pixel 7, and held low for 10 cycles, then raised -> outputs at inactive levels one cycle after the drop; frame_start one cycle after re-enable.
- With TPG_MOVING_BOX_EN and BOX_SIZE = 4, checkerboard -> box at (0,0) frame 1, (1,1) frame 2; after 12 frames box_x reaches 12 and decreases next frame; pixels inside the box are inverted.
